// File: rtl/hazard_controller.sv
// hazard_controller
// Pipeline sequencing controller for the 16-bit core. Shadow EX/MEM/WB slots
// track in-flight register writers. These slots are compared against the
// decode-stage instruction to produce:
//   - stall controls for PC, IF/ID and ID/EX
//   - the IF flush for a taken jump
//   - the decode comparator forwarding selects
//   - a saturating count of stalled cycles
module hazard_controller #(
  parameter int         REG_AW  = 3,
  parameter logic [1:0] SEL_MEM = 2'd0,
  parameter logic [1:0] SEL_WB  = 2'd1,
  parameter logic [1:0] SEL_RF  = 2'd2,
  parameter int         CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic              id_is_branch_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              id_jump_n_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o,
  output logic              if_flush_o,
  output logic [1:0]        cmp_mux1_ctl_o,
  output logic [1:0]        cmp_mux2_ctl_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  // EX slot: youngest in-flight instruction
  logic              exV_q, exV_d;
  logic [REG_AW-1:0] exRd_q, exRd_d;
  logic              exRw_q, exRw_d;
  logic              exMr_q, exMr_d;

  // MEM slot: the load flag still matters here because load data is not yet available
  logic              memV_q, memV_d;
  logic [REG_AW-1:0] memRd_q, memRd_d;
  logic              memRw_q, memRw_d;
  logic              memMr_q, memMr_d;

  // WB slot: every writer's result is available by now, so the load flag is not kept
  logic              wbV_q, wbV_d;
  logic [REG_AW-1:0] wbRd_q, wbRd_d;
  logic              wbRw_q, wbRw_d;

  logic [CNT_W-1:0]  count_q, count_d;

  logic m1Ex, m1Mem, m1Wb;
  logic m2Ex, m2Mem, m2Wb;
  logic hazard1, hazard2;
  logic stall;

  // A slot matches a source when it holds a real writer of that non-zero register
  // and the decode instruction actually reads it
  function automatic logic slotMatch(
    input logic              v,
    input logic              rw,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] r,
    input logic              useR
  );
    return v & rw & (rd == r) & (r != '0) & useR;
  endfunction

  // Comparator operand select: MEM forwarding only for non-loads, then WB, then the register file
  function automatic logic [1:0] selFor(
    input logic mMem,
    input logic mWb,
    input logic mMemLoad
  );
    if (mMem & ~mMemLoad) begin
      return SEL_MEM;
    end else if (mWb) begin
      return SEL_WB;
    end else begin
      return SEL_RF;
    end
  endfunction

  // Per-operand match terms against each shadow slot
  always_comb begin
    m1Ex  = slotMatch(exV_q,  exRw_q,  exRd_q,  id_rs1_i, id_use_rs1_i);
    m1Mem = slotMatch(memV_q, memRw_q, memRd_q, id_rs1_i, id_use_rs1_i);
    m1Wb  = slotMatch(wbV_q,  wbRw_q,  wbRd_q,  id_rs1_i, id_use_rs1_i);
    m2Ex  = slotMatch(exV_q,  exRw_q,  exRd_q,  id_rs2_i, id_use_rs2_i);
    m2Mem = slotMatch(memV_q, memRw_q, memRd_q, id_rs2_i, id_use_rs2_i);
    m2Wb  = slotMatch(wbV_q,  wbRw_q,  wbRd_q,  id_rs2_i, id_use_rs2_i);
  end

  // Hazard detection: branches need their operands in decode, ALU ops only trip on load-use
  always_comb begin
    if (id_is_branch_i) begin
      hazard1 = m1Ex | (m1Mem & memMr_q);
      hazard2 = m2Ex | (m2Mem & memMr_q);
    end else begin
      hazard1 = m1Ex & exMr_q;
      hazard2 = m2Ex & exMr_q;
    end
    stall = rst_ni & id_valid_i & (hazard1 | hazard2);
  end

  // Pipeline control and comparator selects, all forced to their idle values during reset
  always_comb begin
    pc_write_o     = ~stall;
    ifid_write_o   = ~stall;
    idex_bubble_o  = stall;
    if_flush_o     = rst_ni & id_valid_i & ~id_jump_n_i & ~stall;
    cmp_mux1_ctl_o = SEL_RF;
    cmp_mux2_ctl_o = SEL_RF;
    if (rst_ni & id_valid_i & id_is_branch_i) begin
      cmp_mux1_ctl_o = selFor(m1Mem, m1Wb, memMr_q);
      cmp_mux2_ctl_o = selFor(m2Mem, m2Wb, memMr_q);
    end
    stall_count_o  = count_q;
  end

  // Next-state of the shadow pipeline and stall counter; a stalled decode enters EX as a bubble
  always_comb begin
    exV_d   = id_valid_i & ~stall;
    exRd_d  = id_rd_i;
    exRw_d  = id_reg_write_i;
    exMr_d  = id_mem_read_i;
    memV_d  = exV_q;
    memRd_d = exRd_q;
    memRw_d = exRw_q;
    memMr_d = exMr_q;
    wbV_d   = memV_q;
    wbRd_d  = memRd_q;
    wbRw_d  = memRw_q;
    count_d = count_q;
    if (stall && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // State registers; reset empties every slot so no hazard outlives it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exV_q   <= 1'b0;
      exRd_q  <= '0;
      exRw_q  <= 1'b0;
      exMr_q  <= 1'b0;
      memV_q  <= 1'b0;
      memRd_q <= '0;
      memRw_q <= 1'b0;
      memMr_q <= 1'b0;
      wbV_q   <= 1'b0;
      wbRd_q  <= '0;
      wbRw_q  <= 1'b0;
      count_q <= '0;
    end else begin
      exV_q   <= exV_d;
      exRd_q  <= exRd_d;
      exRw_q  <= exRw_d;
      exMr_q  <= exMr_d;
      memV_q  <= memV_d;
      memRd_q <= memRd_d;
      memRw_q <= memRw_d;
      memMr_q <= memMr_d;
      wbV_q   <= wbV_d;
      wbRd_q  <= wbRd_d;
      wbRw_q  <= wbRw_d;
      count_q <= count_d;
    end
  end

endmodule
